// File: rtl/mux3.sv
// ============================================================================
// Module      : mux3
// Description : 3:1 select with a combinational output and a valid-qualified
//               registered copy; an illegal select is flagged and latched.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux3 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    input  logic             in_valid,
    output logic             sel_err,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             err_sticky
);

    localparam logic [1:0] C_SEL_D0  = 2'b00;
    localparam logic [1:0] C_SEL_D1  = 2'b01;
    localparam logic [1:0] C_SEL_D2  = 2'b10;

    logic [WIDTH-1:0] w_y;
    logic             w_sel_err;
    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic             r_err_sticky;

    // The illegal select drives zeros, so y_q captures zeros for it as well.
    always_comb begin
        w_y       = '0;
        w_sel_err = 1'b0;
        case (s)
            C_SEL_D0: w_y = d0;
            C_SEL_D1: w_y = d1;
            C_SEL_D2: w_y = d2;
            default:  w_sel_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_y_q        <= '0;
            r_out_valid  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y_q <= w_y;
                if (w_sel_err) begin
                    r_err_sticky <= 1'b1;
                end
            end
        end
    end

    assign y          = w_y;
    assign sel_err    = w_sel_err;
    assign y_q        = r_y_q;
    assign out_valid  = r_out_valid;
    assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_mux3.sv
// ============================================================================
// Module      : tb_mux3
// Description : Directed vectors for mux3 (WIDTH=4); registered results are
//               queued by the driver and compared by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux3;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] y_q;
        logic             out_valid;
        logic             err_sticky;
    } reg_exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] d0 = '0;
    logic [WIDTH-1:0] d1 = '0;
    logic [WIDTH-1:0] d2 = '0;
    logic [1:0]       s = 2'b00;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] y;
    logic             sel_err;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;
    logic             err_sticky;

    int errors = 0;
    int checks = 0;
    reg_exp_t exp_q[$];

    mux3 #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .d0         (d0),
        .d1         (d1),
        .d2         (d2),
        .s          (s),
        .y          (y),
        .in_valid   (in_valid),
        .sel_err    (sel_err),
        .y_q        (y_q),
        .out_valid  (out_valid),
        .err_sticky (err_sticky)
    );

    always #5 clock = ~clock;

    // Apply one vector mid-cycle, check the combinational path at once and
    // queue what the registers must hold after the next rising edge.
    task automatic step(input string name, input logic rst, input logic v,
                        input logic [1:0] sel, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                        input logic [WIDTH-1:0] exp_y, input logic exp_se,
                        input logic [WIDTH-1:0] exp_yq, input logic exp_ov,
                        input logic exp_st);
        reg_exp_t e;
        @(negedge clock);
        reset = rst; in_valid = v; s = sel; d0 = a; d1 = b; d2 = c;
        #1;
        checks++;
        if (y !== exp_y) begin
            errors++;
            $display("FAIL %s y: got %h expected %h", name, y, exp_y);
        end
        checks++;
        if (sel_err !== exp_se) begin
            errors++;
            $display("FAIL %s sel_err: got %b expected %b", name, sel_err, exp_se);
        end
        e.y_q = exp_yq; e.out_valid = exp_ov; e.err_sticky = exp_st;
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, compare registered outputs to the
    // oldest queued expectation.
    initial begin
        reg_exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (y_q !== e.y_q) begin
                    errors++;
                    $display("FAIL y_q: got %h expected %h at %0t", y_q, e.y_q, $time);
                end
                checks++;
                if (out_valid !== e.out_valid) begin
                    errors++;
                    $display("FAIL out_valid: got %b expected %b at %0t", out_valid, e.out_valid, $time);
                end
                checks++;
                if (err_sticky !== e.err_sticky) begin
                    errors++;
                    $display("FAIL err_sticky: got %b expected %b at %0t", err_sticky, e.err_sticky, $time);
                end
            end
        end
    end

    initial begin
        //    name           rst v  s      d0    d1    d2    y     se    y_q   ov    st
        step("rst_a",        1, 0, 2'b00, 4'h0, 4'h1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        step("rst_ill",      1, 1, 2'b11, 4'h0, 4'h1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0);
        step("sel0",         0, 1, 2'b00, 4'h0, 4'h1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0);
        step("sel1",         0, 1, 2'b01, 4'h0, 4'h1, 4'hF, 4'h1, 1'b0, 4'h1, 1'b1, 1'b0);
        step("sel2",         0, 1, 2'b10, 4'h0, 4'h1, 4'hF, 4'hF, 1'b0, 4'hF, 1'b1, 1'b0);
        step("illegal",      0, 1, 2'b11, 4'h0, 4'h1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1);
        step("sticky_keep",  0, 1, 2'b00, 4'h0, 4'h1, 4'hF, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
        step("cap_f",        0, 1, 2'b10, 4'h0, 4'h1, 4'hF, 4'hF, 1'b0, 4'hF, 1'b1, 1'b1);
        step("hold",         0, 0, 2'b01, 4'h0, 4'h1, 4'hF, 4'h1, 1'b0, 4'hF, 1'b0, 1'b1);
        step("recap_f",      0, 1, 2'b10, 4'h0, 4'h1, 4'hF, 4'hF, 1'b0, 4'hF, 1'b1, 1'b1);
        step("rst_mid",      1, 1, 2'b01, 4'h0, 4'h1, 4'hF, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0);
        step("ill_noval",    0, 0, 2'b11, 4'h0, 4'h1, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0);
        step("data_b_s1",    0, 1, 2'b01, 4'hA, 4'h5, 4'h3, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0);
        step("data_b_s0",    0, 1, 2'b00, 4'hA, 4'h5, 4'h3, 4'hA, 1'b0, 4'hA, 1'b1, 1'b0);
        step("data_b_s2",    0, 1, 2'b10, 4'hA, 4'h5, 4'h3, 4'h3, 1'b0, 4'h3, 1'b1, 1'b0);
        step("drop_valid",   0, 0, 2'b00, 4'h6, 4'h5, 4'h3, 4'h6, 1'b0, 4'h3, 1'b0, 1'b0);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(posedge clock);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux3.md
MUX3 -- requirements
Module: mux3

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every data input and output.
REQ-002 clock  input  1  system clock; all sequential logic updates on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-004 d0  input  WIDTH  data input 0.
REQ-005 d1  input  WIDTH  data input 1.
REQ-006 d2  input  WIDTH  data input 2.
REQ-007 s  input  2  select.
REQ-008 in_valid  input  1  qualifies s/d0..d2 for the registered path.
REQ-009 y  output  WIDTH  combinational mux output.
REQ-010 sel_err  output  1  combinational illegal-select flag.
REQ-011 y_q  output  WIDTH  registered mux output.
REQ-012 out_valid  output  1  y_q holds a value captured with in_valid=1.
REQ-013 err_sticky  output  1  latched illegal-select-while-valid flag.
REQ-014 The port order SHALL be clock, reset, d0, d1, d2, s, y, in_valid, sel_err, y_q, out_valid, err_sticky; benches SHALL connect ports by name.

Function
REQ-015 y SHALL equal d0 when s=2'b00, d1 when s=2'b01, d2 when s=2'b10, with zero latency.
REQ-016 y SHALL equal all-zeros when s=2'b11.
REQ-017 sel_err SHALL be 1 exactly when s=2'b11, with zero latency.
REQ-018 y and sel_err SHALL be independent of clock, reset and in_valid, including during reset.
REQ-019 y SHALL track every change on d0..d2 and s combinationally; no latches are permitted.
REQ-020 On a rising edge with reset=0 and in_valid=1, y_q SHALL load the current y value, so y_q lags y by one cycle.
REQ-021 On a rising edge with reset=0 and in_valid=1, out_valid SHALL load 1.
REQ-022 On a rising edge with reset=0 and in_valid=0, y_q SHALL hold its previous value and out_valid SHALL load 0.
REQ-023 err_sticky SHALL set on a rising edge with reset=0, in_valid=1 and s=2'b11.
REQ-024 err_sticky SHALL remain 1 until reset; no other input clears it.
REQ-025 When s=2'b11 is captured with in_valid=1, y_q SHALL load all-zeros and out_valid SHALL load 1.
REQ-026 All widths SHALL be exact WIDTH bits; no truncation or extension between inputs, y and y_q.

Reset
REQ-027 On a rising edge with reset=1, y_q SHALL load 0, out_valid SHALL load 0 and err_sticky SHALL load 0, regardless of in_valid, s and d0..d2.
REQ-028 Reset SHALL take priority over every capture; asserting reset mid-stream SHALL discard the value presented in that cycle.
REQ-029 On the first edge after reset deasserts, the outputs SHALL behave per REQ-020 to REQ-025.
REQ-030 Before the first reset edge, the registered outputs are undefined; y and sel_err are valid at all times.

Verification (WIDTH=4)
REQ-031 Select 0: d0=0, d1=1, d2=F, s=00 -> y=0, sel_err=0.
REQ-032 Select 1 then 2: same data, s=01 -> y=1; then s=10 -> y=F; both with sel_err=0.
REQ-033 Illegal select: s=11 with in_valid=1, then one clock -> y=0, sel_err=1 immediately; after the edge y_q=0, out_valid=1, err_sticky=1; err_sticky stays 1 after s returns to 00.
REQ-034 Registered hold: capture s=10 (y_q=F), then drop in_valid and change s to 01 -> y=1 immediately; y_q stays F and out_valid=0 on the next edge.
REQ-035 Reset mid-operation: with err_sticky=1, y_q=F, out_valid=1, assert reset for one edge while in_valid=1 and s=01 -> y_q=0, out_valid=0, err_sticky=0, while y=1 throughout.
